// File: rtl/systolic_tile.sv
// systolic_tile: weight-stationary R x C signed MAC array with built-in input skew,
// output deskew and a drain-protected, double-buffered weight store.
module systolic_tile #(
   parameter  int DATA_W = 8,
   parameter  int ACC_W  = 32,
   parameter  int N_ROWS = 32,
   parameter  int N_COLS = 32,
   localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
   localparam int LAT    = N_ROWS + N_COLS,
   localparam int CNT_W  = $clog2(LAT + 1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [N_ROWS-1:0][DATA_W-1:0]  in_act,
   input  logic [N_COLS-1:0][ACC_W-1:0]   in_psum,
   input  logic                           wt_valid,
   input  logic [ROW_W-1:0]               wt_row,
   input  logic [N_COLS-1:0][DATA_W-1:0]  wt_data,
   input  logic                           wt_commit,
   output logic                           wt_busy,
   output logic                           active_bank,
   output logic                           out_valid,
   output logic [N_COLS-1:0][ACC_W-1:0]   out_data
);

   typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

   state_t                        state;
   logic                          accept;
   logic [CNT_W-1:0]              in_flight;
   logic [LAT-1:0]                vld_chain;
   logic [DATA_W-1:0]             wbank [2][N_ROWS][N_COLS];
   logic [N_ROWS-1:0][DATA_W-1:0] a_src;
   logic [N_COLS-1:0][ACC_W-1:0]  p_src;
   logic [N_COLS-1:0][ACC_W-1:0]  col_out;
   logic [DATA_W-1:0]             a_pe  [N_ROWS][N_COLS];
   logic [ACC_W-1:0]              ps_pe [N_ROWS][N_COLS];

   assign accept = in_valid && in_ready;

   function automatic logic [ACC_W-1:0] mac(input logic [ACC_W-1:0]  acc,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] w);
      logic signed [2*DATA_W-1:0] prod;
      prod = $signed(a) * $signed(w);
      return acc + ACC_W'(prod);
   endfunction

   // Commit FSM; in_ready/wt_busy/active_bank are registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         in_ready    <= 1'b1;
         wt_busy     <= 1'b0;
         active_bank <= 1'b0;
      end else begin
         case (state)
            RUN: if (wt_commit) begin
               state    <= DRAIN;
               in_ready <= 1'b0;
               wt_busy  <= 1'b1;
            end
            DRAIN: if (in_flight == '0) state <= SWAP;
            SWAP: begin
               state       <= RUN;
               in_ready    <= 1'b1;
               wt_busy     <= 1'b0;
               active_bank <= ~active_bank;
            end
            default: state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         in_flight <= '0;
      else if (accept && !out_valid)
         in_flight <= in_flight + CNT_W'(1);
      else if (!accept && out_valid)
         in_flight <= in_flight - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the banks are architectural state (a freshly reset tile computes with
         // zero weights), so unlike a RAM they take the reset.
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < N_ROWS; r++)
               for (int c = 0; c < N_COLS; c++)
                  wbank[b][r][c] <= '0;
      end else if (wt_valid && !wt_busy && int'(wt_row) < N_ROWS) begin
         for (int c = 0; c < N_COLS; c++)
            wbank[~active_bank][wt_row][c] <= wt_data[c];
      end
   end

   // Row r activation reaches column 0 r cycles after the accept edge; bubbles enter as 0.
   for (genvar r = 0; r < N_ROWS; r++) begin : g_row_skew
      logic [DATA_W-1:0] head;
      assign head = accept ? in_act[r] : '0;
      if (r == 0) begin : g_direct
         assign a_src[r] = head;
      end else begin : g_dly
         logic [DATA_W-1:0] dly [r];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < r; k++) dly[k] <= '0;
            end else begin
               dly[0] <= head;
               for (int k = 1; k < r; k++) dly[k] <= dly[k-1];
            end
         end
         assign a_src[r] = dly[r-1];
      end
   end

   // The seed for column c must meet the activation of row 0, which arrives at PE(0,c) c cycles late.
   for (genvar c = 0; c < N_COLS; c++) begin : g_psum_skew
      logic [ACC_W-1:0] dly [c+1];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k <= c; k++) dly[k] <= '0;
         end else begin
            dly[0] <= accept ? in_psum[c] : '0;
            for (int k = 1; k <= c; k++) dly[k] <= dly[k-1];
         end
      end
      assign p_src[c] = dly[c];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < N_ROWS; r++)
            for (int c = 0; c < N_COLS; c++) begin
               a_pe[r][c]  <= '0;
               ps_pe[r][c] <= '0;
            end
      end else begin
         for (int r = 0; r < N_ROWS; r++) begin
            a_pe[r][0] <= a_src[r];
            for (int c = 1; c < N_COLS; c++) a_pe[r][c] <= a_pe[r][c-1];
         end
         for (int c = 0; c < N_COLS; c++) begin
            ps_pe[0][c] <= mac(p_src[c], a_pe[0][c], wbank[active_bank][0][c]);
            for (int r = 1; r < N_ROWS; r++)
               ps_pe[r][c] <= mac(ps_pe[r-1][c], a_pe[r][c], wbank[active_bank][r][c]);
         end
      end
   end

   for (genvar c = 0; c < N_COLS; c++) begin : g_deskew
      if (c == N_COLS - 1) begin : g_direct
         assign col_out[c] = ps_pe[N_ROWS-1][c];
      end else begin : g_dly
         logic [ACC_W-1:0] dly [N_COLS-1-c];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < N_COLS - 1 - c; k++) dly[k] <= '0;
            end else begin
               dly[0] <= ps_pe[N_ROWS-1][c];
               for (int k = 1; k < N_COLS - 1 - c; k++) dly[k] <= dly[k-1];
            end
         end
         assign col_out[c] = dly[N_COLS-2-c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_chain <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         vld_chain <= {vld_chain[LAT-2:0], accept};
         out_valid <= vld_chain[LAT-1];
         if (vld_chain[LAT-1]) out_data <= col_out;
      end
   end

endmodule

// File: tb/tb_systolic_tile.sv
// tb_systolic_tile: 4x4 systolic tile against a vector-level reference model plus
// hand-computed directed expectations.
module tb_systolic_tile;

   localparam int R = 4, C = 4, DW = 8, AW = 32, L = R + C;

   typedef logic [R-1:0][DW-1:0]        act_t;
   typedef logic [C-1:0][AW-1:0]        psum_t;
   typedef logic [C-1:0][DW-1:0]        wrow_t;
   typedef logic [R-1:0][C-1:0][DW-1:0] wmat_t;
   typedef struct { int due; psum_t y; } res_t;

   logic  clk = 1'b0, rst_n = 1'b0;
   logic  in_valid = 1'b0, wt_valid = 1'b0, wt_commit = 1'b0;
   act_t  in_act = '0;
   psum_t in_psum = '0;
   logic [1:0] wt_row = '0;
   wrow_t wt_data = '0;
   logic  in_ready, wt_busy, active_bank, out_valid;
   psum_t out_data;

   systolic_tile #(.DATA_W(DW), .ACC_W(AW), .N_ROWS(R), .N_COLS(C)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_act(in_act), .in_psum(in_psum), .wt_valid(wt_valid), .wt_row(wt_row),
      .wt_data(wt_data), .wt_commit(wt_commit), .wt_busy(wt_busy),
      .active_bank(active_bank), .out_valid(out_valid), .out_data(out_data));

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: vector-level arithmetic, in-flight bookkeeping and commit phases.
   res_t  q[$];
   int    mw [2][R][C];
   int    m_phase = 0;   // 0 run, 1 drain, 2 swap
   logic  m_bank = 1'b0, exp_valid = 1'b0, exp_ready = 1'b1, exp_busy = 1'b0;
   psum_t exp_data = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if (clk) cyc++;
         q.delete();
         foreach (mw[b, r, c]) mw[b][r][c] = 0;
         m_phase = 0; m_bank = 1'b0; exp_valid = 1'b0; exp_data = '0;
         exp_ready = 1'b1; exp_busy = 1'b0;
      end else begin
         int inflight;
         res_t e;
         cyc++;
         inflight = q.size() + (exp_valid ? 1 : 0);
         if (wt_valid && !exp_busy)
            for (int c = 0; c < C; c++) mw[!m_bank][wt_row][c] = int'($signed(wt_data[c]));
         if (in_valid && exp_ready) begin
            for (int c = 0; c < C; c++) begin
               int s;
               s = $signed(in_psum[c]);
               for (int r = 0; r < R; r++) s += int'($signed(in_act[r])) * mw[m_bank][r][c];
               e.y[c] = s;
            end
            e.due = cyc + L;
            q.push_back(e);
         end
         case (m_phase)
            0: if (wt_commit) m_phase = 1;
            1: if (inflight == 0) m_phase = 2;
            default: begin m_phase = 0; m_bank = !m_bank; end
         endcase
         exp_ready = (m_phase == 0);
         exp_busy  = (m_phase != 0);
         exp_valid = 1'b0;
         if (q.size() > 0 && q[0].due == cyc) begin
            exp_valid = 1'b1;
            exp_data  = q[0].y;
            void'(q.pop_front());
         end
      end
   end

   psum_t cap_data [128];
   int    cap_cyc  [128];
   int    cap_n = 0;

   always @(posedge clk) begin
      #1;
      check("out_valid", longint'(out_valid), longint'(exp_valid));
      for (int c = 0; c < C; c++)
         check($sformatf("out_data[%0d]", c), longint'($signed(out_data[c])), longint'($signed(exp_data[c])));
      check("in_ready", longint'(in_ready), longint'(exp_ready));
      check("wt_busy", longint'(wt_busy), longint'(exp_busy));
      check("active_bank", longint'(active_bank), longint'(m_bank));
      if (out_valid && cap_n < 128) begin
         cap_data[cap_n] = out_data;
         cap_cyc[cap_n]  = cyc;
         cap_n++;
      end
   end

   function automatic act_t mk_act(input int a0, input int a1, input int a2, input int a3);
      return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
   endfunction

   function automatic psum_t mk_psum(input int p0, input int p1, input int p2, input int p3);
      return {32'(p3), 32'(p2), 32'(p1), 32'(p0)};
   endfunction

   function automatic wmat_t w_mat(input int diag, input int offd);
      wmat_t w;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) w[r][c] = 8'((r == c) ? diag : offd);
      return w;
   endfunction

   task automatic tick(); @(negedge clk); endtask

   task automatic load_shadow(input wmat_t w);
      for (int r = 0; r < R; r++) begin
         wt_valid = 1'b1; wt_row = 2'(r); wt_data = w[r];
         tick();
      end
      wt_valid = 1'b0;
   endtask

   task automatic commit_and_wait(output int low);
      wt_commit = 1'b1;
      tick();
      wt_commit = 1'b0;
      low = 0;
      while (!in_ready && low < 100) begin low++; tick(); end
      check("commit_ready_timeout", longint'(in_ready), 1);
   endtask

   task automatic send(input act_t a, input psum_t p);
      in_valid = 1'b1; in_act = a; in_psum = p;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_caps(input int target);
      int n = 0;
      while (cap_n < target && n < 200) begin n++; tick(); end
      check("wait_out_valid_timeout", cap_n, target);
   endtask

   initial begin
      int base, acc_edge, low;
      wmat_t w;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      // 1. Reset state.
      check("t1_out_valid", longint'(out_valid), 0);
      check("t1_in_ready", longint'(in_ready), 1);
      check("t1_wt_busy", longint'(wt_busy), 0);
      check("t1_active_bank", longint'(active_bank), 0);
      for (int c = 0; c < C; c++) check($sformatf("t1_out_data[%0d]", c), longint'(out_data[c]), 0);

      // 2. Identity weights, one vector, exact latency.
      load_shadow(w_mat(1, 0));
      commit_and_wait(low);
      check("t2_commit_low_cycles", low, 2);
      base = cap_n;
      acc_edge = cyc + 1;
      send(mk_act(1, 2, 3, 4), mk_psum(10, 20, 30, 40));
      repeat (L + 2) tick();
      check("t2_pulses", cap_n - base, 1);
      check("t2_latency", cap_cyc[base] - acc_edge, 8);
      check("t2_y0", $signed(cap_data[base][0]), 11);
      check("t2_y1", $signed(cap_data[base][1]), 22);
      check("t2_y2", $signed(cap_data[base][2]), 33);
      check("t2_y3", $signed(cap_data[base][3]), 44);
      check("t2_bank", longint'(active_bank), 1);

      // 3. Back-to-back stream, all-ones weights.
      load_shadow(w_mat(1, 1));
      commit_and_wait(low);
      base = cap_n;
      for (int k = 0; k < 16; k++) begin
         in_valid = 1'b1; in_act = mk_act(k, k, k, k); in_psum = '0;
         tick();
      end
      in_valid = 1'b0;
      wait_caps(base + 16);
      repeat (4) tick();
      check("t3_beats", cap_n - base, 16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t3_gap%0d", i), cap_cyc[base+i] - cap_cyc[base], i);
         for (int c = 0; c < C; c++)
            check($sformatf("t3_y%0d_%0d", i, c), $signed(cap_data[base+i][c]), 4 * i);
      end

      // 4. Commit with three vectors in flight; write during drain must be dropped.
      load_shadow(w_mat(2, 0));
      base = cap_n;
      send(mk_act(1, 2, 3, 4), '0);
      send(mk_act(1, 2, 3, 4), '0);
      wt_commit = 1'b1;
      send(mk_act(1, 2, 3, 4), '0);
      wt_commit = 1'b0;
      low = 0;
      while (!in_ready && low < 100) begin
         low++;
         wt_valid = (low == 2); wt_row = 2'd0; wt_data = {C{8'd7}};
         tick();
      end
      wt_valid = 1'b0;
      check("t4_ready_low_cycles", low, 11);
      check("t4_old_results", cap_n - base, 3);
      for (int i = 0; i < 3; i++)
         for (int c = 0; c < C; c++)
            check($sformatf("t4_old%0d_%0d", i, c), $signed(cap_data[base+i][c]), 10);
      base = cap_n;
      send(mk_act(1, 1, 1, 1), '0);
      wait_caps(base + 1);
      for (int c = 0; c < C; c++) check($sformatf("t4_new_%0d", c), $signed(cap_data[base][c]), 2);
      check("t4_bank", longint'(active_bank), 1);

      // 5. Signed extremes and modulo-2^32 wrap.
      load_shadow(w_mat(-128, -128));
      commit_and_wait(low);
      base = cap_n;
      send(mk_act(-128, -128, -128, -128), '0);
      wait_caps(base + 1);
      for (int c = 0; c < C; c++) check($sformatf("t5_neg_%0d", c), $signed(cap_data[base][c]), 65536);
      w = w_mat(0, 0);
      w[0][0] = 8'd1;
      load_shadow(w);
      commit_and_wait(low);
      base = cap_n;
      send(mk_act(1, 0, 0, 0), mk_psum(2147483647, 0, 0, 0));
      wait_caps(base + 1);
      check("t5_wrap_y0", $signed(cap_data[base][0]), -64'sd2147483648);
      check("t5_wrap_y1", $signed(cap_data[base][1]), 0);

      // 6. Reset with five vectors in flight.
      for (int k = 1; k <= 5; k++) begin
         in_valid = 1'b1; in_act = mk_act(k, k, k, k); in_psum = '0;
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      base = cap_n;
      repeat (20) tick();
      check("t6_no_out_valid", cap_n - base, 0);
      check("t6_bank", longint'(active_bank), 0);
      check("t6_in_ready", longint'(in_ready), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
